// File: rtl/bec_job_arbiter_pkg.sv
// Shared types and constants for the bec_job_arbiter slice: state encoding,
// default field width and operand-bundle indices.
package bec_pkg;

    localparam int BEC_WIDTH = 163;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b11,
        ST_RESP = 2'b10
    } state_t;

    localparam int OP_W1     = 0;
    localparam int OP_Z1     = 1;
    localparam int OP_W2     = 2;
    localparam int OP_Z2     = 3;
    localparam int OP_INV_W0 = 4;
    localparam int OP_D      = 5;
    localparam int OP_KEY    = 6;
    localparam int OP_NUM    = 7;

endpackage

// File: rtl/bec_job_arbiter_if.sv
// Requester, response and core-side signals of bec_job_arbiter.
// slave = arbiter side, master = requesters + core environment.
interface bec_job_arbiter_if
    import bec_pkg::*;
#(
    parameter int WIDTH = BEC_WIDTH
);
    logic             req0, req1, gnt0, gnt1;
    logic [WIDTH-1:0] req0_w1, req0_z1, req0_w2, req0_z2, req0_inv_w0, req0_d, req0_key;
    logic [WIDTH-1:0] req1_w1, req1_z1, req1_w2, req1_z2, req1_inv_w0, req1_d, req1_key;
    logic             res_valid, res_ready, res_id, res_err;
    logic [WIDTH-1:0] res_wout, res_zout;
    logic             core_enable, core_ki, core_next_key, core_done;
    logic [WIDTH-1:0] core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d;
    logic [WIDTH-1:0] core_wout, core_zout;
    logic             busy;
    logic [7:0]       bit_cnt;

    modport slave (
        input  req0, req1,
        input  req0_w1, req0_z1, req0_w2, req0_z2, req0_inv_w0, req0_d, req0_key,
        input  req1_w1, req1_z1, req1_w2, req1_z2, req1_inv_w0, req1_d, req1_key,
        input  res_ready, core_next_key, core_done, core_wout, core_zout,
        output gnt0, gnt1, res_valid, res_id, res_err, res_wout, res_zout,
        output core_enable, core_ki, core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d,
        output busy, bit_cnt
    );

    modport master (
        output req0, req1,
        output req0_w1, req0_z1, req0_w2, req0_z2, req0_inv_w0, req0_d, req0_key,
        output req1_w1, req1_z1, req1_w2, req1_z2, req1_inv_w0, req1_d, req1_key,
        output res_ready, core_next_key, core_done, core_wout, core_zout,
        input  gnt0, gnt1, res_valid, res_id, res_err, res_wout, res_zout,
        input  core_enable, core_ki, core_w1, core_z1, core_w2, core_z2, core_inv_w0, core_d,
        input  busy, bit_cnt
    );

endinterface

// File: rtl/bec_job_arbiter_rr_arb2.sv
// Two-input round-robin picker: on contention the requester opposite the
// last grant wins; a lone request always wins.
module bec_rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_gnt,
    output logic o_sel,
    output logic o_any
);

    assign o_any = i_req0 | i_req1;
    assign o_sel = (i_req0 & i_req1) ? ~i_last_gnt : i_req1;

endmodule

// File: rtl/bec_job_arbiter.sv
// Shares one sm_bec_v3 core between two requesters: arbitrate, load operands,
// serialise the key, return the tagged result. Optional watchdog: BEC_ARB_WATCHDOG_EN.
module bec_job_arbiter
    import bec_pkg::*;
#(
    parameter int WIDTH          = BEC_WIDTH,
    parameter int KEY_BITS       = 163,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic              clk,
    input logic              rst_n,
    bec_job_arbiter_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic              r_sel, r_last_gnt, w_sel, w_any;
    logic [WIDTH-1:0]  r_w1, r_z1, r_w2, r_z2, r_inv_w0, r_d;
    logic [WIDTH-1:0]  r_res_wout, r_res_zout;
    logic [KEY_BITS-1:0] r_key_sr;
    logic [7:0]        r_bit_cnt;
    logic [WIDTH-1:0]  w_ops [OP_NUM];
    logic              w_timeout, w_res_err;
    logic              w_gnt0, w_gnt1, w_res_valid, w_core_enable, w_busy;

    bec_rr_arb2 u_arb (
        .i_req0     (bus.req0),
        .i_req1     (bus.req1),
        .i_last_gnt (r_last_gnt),
        .o_sel      (w_sel),
        .o_any      (w_any)
    );

    always_comb begin
        w_ops[OP_W1]     = r_sel ? bus.req1_w1     : bus.req0_w1;
        w_ops[OP_Z1]     = r_sel ? bus.req1_z1     : bus.req0_z1;
        w_ops[OP_W2]     = r_sel ? bus.req1_w2     : bus.req0_w2;
        w_ops[OP_Z2]     = r_sel ? bus.req1_z2     : bus.req0_z2;
        w_ops[OP_INV_W0] = r_sel ? bus.req1_inv_w0 : bus.req0_inv_w0;
        w_ops[OP_D]      = r_sel ? bus.req1_d      : bus.req0_d;
        w_ops[OP_KEY]    = r_sel ? bus.req1_key    : bus.req0_key;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_res_valid   = 1'b0;
        w_core_enable = 1'b0;
        w_busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_gnt0      = ~r_sel;
                w_gnt1      = r_sel;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_core_enable = 1'b1;
                if (bus.core_done || w_timeout) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath follows the registered state so nothing from req reaches core_* combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_w1       <= '0;
            r_z1       <= '0;
            r_w2       <= '0;
            r_z2       <= '0;
            r_inv_w0   <= '0;
            r_d        <= '0;
            r_key_sr   <= '0;
            r_bit_cnt  <= '0;
            r_res_wout <= '0;
            r_res_zout <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) r_sel <= w_sel;
                ST_LOAD: begin
                    r_w1      <= w_ops[OP_W1];
                    r_z1      <= w_ops[OP_Z1];
                    r_w2      <= w_ops[OP_W2];
                    r_z2      <= w_ops[OP_Z2];
                    r_inv_w0  <= w_ops[OP_INV_W0];
                    r_d       <= w_ops[OP_D];
                    r_key_sr  <= w_ops[OP_KEY][KEY_BITS-1:0];
                    r_bit_cnt <= '0;
                end
                ST_RUN: begin
                    if (bus.core_next_key) begin
                        r_key_sr <= r_key_sr >> 1;
                        if (r_bit_cnt != 8'hFF) r_bit_cnt <= r_bit_cnt + 8'd1;
                    end
                    if (bus.core_done) begin
                        r_res_wout <= bus.core_wout;
                        r_res_zout <= bus.core_zout;
                    end else if (w_timeout) begin
                        r_res_wout <= '0;
                        r_res_zout <= '0;
                    end
                end
                ST_RESP: if (bus.res_ready) r_last_gnt <= r_sel;
                default: ;
            endcase
        end
    end

`ifdef BEC_ARB_WATCHDOG_EN
    logic [31:0] r_timer;
    logic        r_res_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_res_err <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_timer <= '0;
        end else if (r_state == ST_RUN) begin
            r_timer <= r_timer + 32'd1;
            if (bus.core_done)  r_res_err <= 1'b0;
            else if (w_timeout) r_res_err <= 1'b1;
        end
    end

    assign w_timeout = (r_timer == 32'(TIMEOUT_CYCLES - 1));
    assign w_res_err = r_res_err;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign w_res_err        = 1'b0;
`endif

    assign bus.gnt0        = w_gnt0;
    assign bus.gnt1        = w_gnt1;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_id      = r_sel;
    assign bus.res_err     = w_res_err;
    assign bus.res_wout    = r_res_wout;
    assign bus.res_zout    = r_res_zout;
    assign bus.core_enable = w_core_enable;
    assign bus.core_ki     = r_key_sr[0];
    assign bus.core_w1     = r_w1;
    assign bus.core_z1     = r_z1;
    assign bus.core_w2     = r_w2;
    assign bus.core_z2     = r_z2;
    assign bus.core_inv_w0 = r_inv_w0;
    assign bus.core_d      = r_d;
    assign bus.busy        = w_busy;
    assign bus.bit_cnt     = r_bit_cnt;

endmodule

// File: tb/tb_bec_job_arbiter.sv
// Scoreboard bench for bec_job_arbiter: directed jobs with a behavioural core
// model; a monitor pops expected responses at each result handshake.
module tb_bec_job_arbiter;

    localparam int W = 163;

    typedef struct {
        logic         id;
        logic         err;
        logic [W-1:0] wout;
        logic [W-1:0] zout;
        logic [7:0]   bc;
        logic [W-1:0] key;
        bit           chk_key;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   hs_cyc = -100;
    int   n_vec  = 0;
    int   n_err  = 0;

    int           m_mode = 0;
    int           m_cnt  = 0;
    bit           m_inject = 1'b0;
    logic [W-1:0] m_key, m_wout, m_zout;

    logic [W-1:0] opv [2][7];
    logic [W-1:0] w0v, z0v, w1v, z1v;
    exp_t         q[$];

    bec_job_arbiter_if #(.WIDTH(W)) bus ();

    bec_job_arbiter #(.WIDTH(W), .KEY_BITS(W), .TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [W-1:0] mk(input int unsigned s);
        logic [191:0] t;
        t = {s * 32'h9E3779B9, ~s, s ^ 32'hA5A5A5A5, s + 32'h01234567, s * 32'h00010003, 32'hC0DE0000 | s};
        return t[W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void push_exp(input logic id, input logic err, input logic [7:0] bc, input bit chk_key);
        exp_t e;
        e.id      = id;
        e.err     = err;
        e.wout    = err ? '0 : (id ? w1v : w0v);
        e.zout    = err ? '0 : (id ? z1v : z0v);
        e.bc      = bc;
        e.key     = opv[id][6];
        e.chk_key = chk_key;
        q.push_back(e);
    endfunction

    // Core model: one key bit per enabled cycle, then done (mode 0), done with
    // the last bit (mode 1), or never done (mode 2).
    initial begin
        bus.core_next_key = 1'b0;
        bus.core_done     = 1'b0;
        bus.core_wout     = '0;
        bus.core_zout     = '0;
        m_key  = '0;
        m_wout = '0;
        m_zout = '0;
        forever begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                m_cnt  = 0;
                m_key  = '0;
                m_wout = bus.gnt1 ? w1v : w0v;
                m_zout = bus.gnt1 ? z1v : z0v;
            end
            bus.core_next_key = 1'b0;
            bus.core_done     = 1'b0;
            if (bus.core_enable) begin
                if (m_cnt < W) begin
                    m_key[m_cnt]      = bus.core_ki;
                    m_cnt++;
                    bus.core_next_key = 1'b1;
                    if (m_mode == 1 && m_cnt == W) bus.core_done = 1'b1;
                end else if (m_mode == 2) begin
                    bus.core_next_key = 1'b1;
                end else begin
                    bus.core_done = 1'b1;
                end
            end else if (m_inject) begin
                bus.core_next_key = cyc[0];
                bus.core_done     = ~cyc[0];
            end
            bus.core_wout = m_wout;
            bus.core_zout = m_zout;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.res_valid && bus.res_ready) begin
                hs_cyc = cyc;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: actual id=%0d with empty queue", bus.res_id);
                end else begin
                    e = q.pop_front();
                    chk("res_id", bus.res_id, e.id);
                    chk("res_err", bus.res_err, e.err);
                    chk("res_wout", bus.res_wout, e.wout);
                    chk("res_zout", bus.res_zout, e.zout);
                    chk("bit_cnt", bus.bit_cnt, e.bc);
                    if (e.chk_key) chk("key_serial", m_key, e.key);
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_err", bus.res_err, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_core_enable", bus.core_enable, 0);
        chk("rst_core_ki", bus.core_ki, 0);
        chk("rst_bit_cnt", bus.bit_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_wout", bus.res_wout, 0);
        chk("rst_core_w1", bus.core_w1, 0);
        chk("rst_core_d", bus.core_d, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input logic id, input int exp_n, input bit chk_hs);
        int n   = 0;
        bit got = 1'b0;
        while (n < 1000 && !got) begin
            @(negedge clk);
            n++;
            if (id ? bus.gnt1 : bus.gnt0) got = 1'b1;
        end
        chk(id ? "gnt1_seen" : "gnt0_seen", got, 1);
        if (got) begin
            chk("gnt_other", id ? bus.gnt0 : bus.gnt1, 0);
            if (exp_n > 0) chk("gnt_latency", n, exp_n);
            if (chk_hs) chk("gnt_after_resp", cyc, hs_cyc + 2);
        end
        if (id) bus.req1 = 1'b0;
        else    bus.req0 = 1'b0;
    endtask

    task automatic check_load(input logic id);
        @(negedge clk);
        chk("core_enable_run", bus.core_enable, 1);
        chk("core_w1", bus.core_w1, opv[id][0]);
        chk("core_z2", bus.core_z2, opv[id][3]);
        chk("core_inv_w0", bus.core_inv_w0, opv[id][4]);
        chk("core_d", bus.core_d, opv[id][5]);
        chk("core_ki_first", bus.core_ki, opv[id][6][0]);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.res_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_seen", bus.res_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.res_valid && bus.res_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("resp_handshake_seen", bus.res_valid && bus.res_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [167:0] fill;
        int           e;
        int           n;
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.res_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 7; k++) opv[r][k] = mk(32'(r * 16 + k + 1));
        fill = {21{8'h5A}};
        w0v  = fill[W-1:0];
        fill = {21{8'h3C}};
        z0v  = fill[W-1:0];
        w1v  = mk(32'd40);
        z1v  = mk(32'd41);
        {bus.req0_w1, bus.req0_z1, bus.req0_w2, bus.req0_z2} = {opv[0][0], opv[0][1], opv[0][2], opv[0][3]};
        {bus.req0_inv_w0, bus.req0_d, bus.req0_key} = {opv[0][4], opv[0][5], opv[0][6]};
        {bus.req1_w1, bus.req1_z1, bus.req1_w2, bus.req1_z2} = {opv[1][0], opv[1][1], opv[1][2], opv[1][3]};
        {bus.req1_inv_w0, bus.req1_d, bus.req1_key} = {opv[1][4], opv[1][5], opv[1][6]};

        reset_dut();

        // Single job from requester 0
        m_mode = 0;
        push_exp(1'b0, 1'b0, 8'd163, 1'b1);
        bus.req0 = 1'b1;
        wait_gnt(1'b0, 1, 1'b0);
        check_load(1'b0);
        wait_idle();

        // Contention after reset, then alternation and late arrivals
        reset_dut();
        m_mode = 1;
        push_exp(1'b0, 1'b0, 8'd163, 1'b1);
        push_exp(1'b1, 1'b0, 8'd163, 1'b1);
        push_exp(1'b0, 1'b0, 8'd163, 1'b1);
        push_exp(1'b1, 1'b0, 8'd163, 1'b1);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        wait_gnt(1'b0, 1, 1'b0);
        check_load(1'b0);
        wait_gnt(1'b1, -1, 1'b1);
        check_load(1'b1);
        repeat (10) @(negedge clk);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        wait_gnt(1'b0, -1, 1'b1);
        check_load(1'b0);
        wait_gnt(1'b1, -1, 1'b1);
        check_load(1'b1);
        wait_idle();

        // Response held off for 20 cycles with stray core pulses
        m_mode = 0;
        bus.res_ready = 1'b0;
        push_exp(1'b1, 1'b0, 8'd163, 1'b1);
        bus.req1 = 1'b1;
        wait_gnt(1'b1, 1, 1'b0);
        check_load(1'b1);
        wait_valid();
        m_inject = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.res_valid, 1);
            chk("hold_id", bus.res_id, 1);
            chk("hold_wout", bus.res_wout, w1v);
            chk("hold_zout", bus.res_zout, z1v);
            chk("hold_bit_cnt", bus.bit_cnt, 163);
        end
        m_inject = 1'b0;
        bus.res_ready = 1'b1;
        wait_idle();

        // Core that never finishes
        m_mode = 2;
        bus.req0 = 1'b1;
`ifdef BEC_ARB_WATCHDOG_EN
        push_exp(1'b0, 1'b1, 8'd100, 1'b0);
        wait_gnt(1'b0, 1, 1'b0);
        check_load(1'b0);
        e = cyc;
        n = 0;
        while (!bus.res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wd_run_cycles", cyc - e, 100);
        wait_idle();
        bus.req0 = 1'b1;
        wait_gnt(1'b0, 1, 1'b0);
        check_load(1'b0);
        repeat (30) @(negedge clk);
`else
        wait_gnt(1'b0, 1, 1'b0);
        check_load(1'b0);
        repeat (300) @(negedge clk);
        chk("nowd_busy", bus.busy, 1);
        chk("nowd_res_valid", bus.res_valid, 0);
        chk("nowd_core_enable", bus.core_enable, 1);
        chk("nowd_bit_cnt_sat", bus.bit_cnt, 255);
`endif

        // One-cycle reset in RUN with req0 pending
        m_mode = 0;
        bus.req0 = 1'b1;
        push_exp(1'b0, 1'b0, 8'd163, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_core_enable", bus.core_enable, 0);
        chk("midrst_bit_cnt", bus.bit_cnt, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        rst_n = 1'b1;
        wait_gnt(1'b0, 1, 1'b0);
        check_load(1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual cycle=%0d required completion", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
